// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the external SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} sram_state_e;

  localparam int BEATS   = 2;
  localparam int SRAM_DW = 16;

  // Cycles spent on one half-word beat: one SETUP plus WAIT_CYC+1 STROBE cycles.
  function automatic int beat_len(input int wait_cyc);
    return wait_cyc + 2;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: core-side 32-bit load/store handshake of the SRAM controller.
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18
);
  logic                       i_req;
  logic                       o_ready;
  logic                       i_we;
  logic [ADDR_W-2:0]          i_addr;
  logic [3:0]                 i_be;
  logic [BEATS*SRAM_DW-1:0]   i_wdata;
  logic [BEATS*SRAM_DW-1:0]   o_rdata;
  logic                       o_rvalid;
  logic                       o_wdone;

  modport master (
    output i_req, i_we, i_addr, i_be, i_wdata,
    input  o_ready, o_rdata, o_rvalid, o_wdone
  );

  modport slave (
    input  i_req, i_we, i_addr, i_be, i_wdata,
    output o_ready, o_rdata, o_rvalid, o_wdone
  );
endinterface

// File: rtl/sram_ctrl_phy.sv
// sram_phy: pin-side registers of the SRAM controller. Every SRAM output comes
// straight from a flop; the controller issues one-cycle-ahead load commands.
module sram_phy
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      ld_setup,
  input  logic [ADDR_W-1:0]         setup_addr,
  input  logic [1:0]                setup_bl_n,
  input  logic                      setup_drive,
  input  logic [SRAM_DW-1:0]        setup_dq,
  input  logic                      ld_strobe,
  input  logic                      strobe_write,
  input  logic                      ld_done,
  input  logic                      release_dq,
  input  logic                      sample,
  input  logic                      sample_hi,
  output logic [BEATS*SRAM_DW-1:0]  rdata,
  output logic [ADDR_W-1:0]         o_sram_addr,
  inout  wire  [SRAM_DW-1:0]        io_sram_dq,
  output logic                      o_sram_ce_n,
  output logic                      o_sram_oe_n,
  output logic                      o_sram_we_n,
  output logic                      o_sram_lb_n,
  output logic                      o_sram_ub_n
);

  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;
  logic [SRAM_DW-1:0] rd_lo;

  assign io_sram_dq = dq_oe ? dq_out : {SRAM_DW{1'bz}};

  // Address and strobe pins: open the beat on SETUP, pulse we_n/oe_n in STROBE, close on DONE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sram_addr <= '0;
      o_sram_ce_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
      o_sram_lb_n <= 1'b1;
      o_sram_ub_n <= 1'b1;
    end else if (ld_setup) begin
      o_sram_addr <= setup_addr;
      o_sram_ce_n <= 1'b0;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
      o_sram_ub_n <= setup_bl_n[1];
      o_sram_lb_n <= setup_bl_n[0];
    end else if (ld_strobe) begin
      o_sram_we_n <= ~strobe_write;
      o_sram_oe_n <= strobe_write;
    end else if (ld_done) begin
      o_sram_ce_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
      o_sram_lb_n <= 1'b1;
      o_sram_ub_n <= 1'b1;
    end
  end

  // Bus enable: released one cycle after the last we_n rise so data outlives the strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dq_oe <= 1'b0;
    end else if (ld_setup) begin
      dq_oe <= setup_drive;
    end else if (release_dq) begin
      dq_oe <= 1'b0;
    end
  end

  // Write half-word presented on the bus for the current beat
  always_ff @(posedge i_clk) begin
    if (ld_setup) dq_out <= setup_dq;
  end

  // Low half of a read is parked until the high half arrives
  always_ff @(posedge i_clk) begin
    if (sample && !sample_hi) rd_lo <= io_sram_dq;
  end

  // Read word updates only when the second half lands, so it holds between reads
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata <= '0;
    end else if (sample && sample_hi) begin
      rdata <= {io_sram_dq, rd_lo};
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit load/store port to 16-bit asynchronous SRAM bridge.
// Each word access runs as two half-word beats (SETUP + WAIT_CYC+1 STROBE cycles).
// Optional build macro SRAM_CTRL_PERF_EN adds saturating read/write completion counters.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int WAIT_CYC   = 1,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sram_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0]  o_sram_addr,
  inout  wire  [SRAM_DW-1:0] io_sram_dq,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n,
  output logic               o_sram_lb_n,
  output logic               o_sram_ub_n
`ifdef SRAM_CTRL_PERF_EN
  ,
  output logic [31:0]        o_rd_cnt,
  output logic [31:0]        o_wr_cnt
`endif
);

  localparam logic [3:0] STROBE_LAST = 4'(beat_len(WAIT_CYC) - 2);

  sram_state_e state;
  logic        beat;
  logic [3:0]  cnt;
  logic        ready, rvalid, wdone;

  logic                     we_q;
  logic [ADDR_W-2:0]        addr_q;
  logic [3:0]               be_q;
  logic [BEATS*SRAM_DW-1:0] wdata_q;

  logic accept, lo_empty_in, hi_empty_in, hi_empty_q, strobe_last;
  logic ld_setup, ld_done, setup_beat, fin_rd, fin_wr;
  logic                     sel_we;
  logic [ADDR_W-2:0]        sel_addr;
  logic [3:0]               sel_be;
  logic [BEATS*SRAM_DW-1:0] sel_wdata;
  logic [1:0]               sel_half_be;

  assign accept      = bus.i_req & ready;
  assign lo_empty_in = SKIP_EMPTY && bus.i_we && (bus.i_be[1:0] == 2'b00);
  assign hi_empty_in = SKIP_EMPTY && bus.i_we && (bus.i_be[3:2] == 2'b00);
  assign hi_empty_q  = SKIP_EMPTY && we_q && (be_q[3:2] == 2'b00);
  assign strobe_last = (state == STROBE) && (cnt == STROBE_LAST);

  // Decide what the pins do at the coming edge: open a beat, or finish the access
  always_comb begin
    ld_setup   = 1'b0;
    ld_done    = 1'b0;
    setup_beat = 1'b0;
    if (accept) begin
      if (lo_empty_in && hi_empty_in) begin
        ld_done = 1'b1;
      end else begin
        ld_setup   = 1'b1;
        setup_beat = lo_empty_in;
      end
    end else if (strobe_last) begin
      if (!beat && !hi_empty_q) begin
        ld_setup   = 1'b1;
        setup_beat = 1'b1;
      end else begin
        ld_done = 1'b1;
      end
    end
  end

  // Beat setup comes from the live request on accept, otherwise from the captured one
  assign sel_we      = accept ? bus.i_we    : we_q;
  assign sel_addr    = accept ? bus.i_addr  : addr_q;
  assign sel_be      = accept ? bus.i_be    : be_q;
  assign sel_wdata   = accept ? bus.i_wdata : wdata_q;
  assign sel_half_be = setup_beat ? sel_be[3:2] : sel_be[1:0];
  assign fin_rd      = ld_done & ~accept & ~we_q;
  assign fin_wr      = ld_done & (accept | we_q);

  // Transaction sequencer with registered handshake outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      beat   <= 1'b0;
      cnt    <= '0;
      ready  <= 1'b1;
      rvalid <= 1'b0;
      wdone  <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      rvalid <= fin_rd;
      wdone  <= fin_wr;
      unique case (state)
        IDLE: begin
          if (accept) begin
            ready <= 1'b0;
            we_q  <= bus.i_we;
            beat  <= setup_beat;
            state <= ld_done ? DONE : SETUP;
          end
        end
        SETUP: begin
          cnt   <= '0;
          state <= STROBE;
        end
        STROBE: begin
          if (strobe_last) begin
            if (ld_setup) begin
              beat  <= 1'b1;
              state <= SETUP;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request payload captured on accept; ignored while busy
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q  <= bus.i_addr;
      be_q    <= bus.i_be;
      wdata_q <= bus.i_wdata;
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_rvalid = rvalid;
  assign bus.o_wdone  = wdone;

  sram_phy #(.ADDR_W(ADDR_W)) u_phy (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .ld_setup     (ld_setup),
    .setup_addr   ({sel_addr, setup_beat}),
    .setup_bl_n   (sel_we ? ~sel_half_be : 2'b00),
    .setup_drive  (sel_we),
    .setup_dq     (setup_beat ? sel_wdata[31:16] : sel_wdata[15:0]),
    .ld_strobe    (state == SETUP),
    .strobe_write (we_q),
    .ld_done      (ld_done),
    .release_dq   (state == DONE),
    .sample       (strobe_last & ~we_q),
    .sample_hi    (beat),
    .rdata        (bus.o_rdata),
    .o_sram_addr  (o_sram_addr),
    .io_sram_dq   (io_sram_dq),
    .o_sram_ce_n  (o_sram_ce_n),
    .o_sram_oe_n  (o_sram_oe_n),
    .o_sram_we_n  (o_sram_we_n),
    .o_sram_lb_n  (o_sram_lb_n),
    .o_sram_ub_n  (o_sram_ub_n)
  );

`ifdef SRAM_CTRL_PERF_EN
  // Completed-access counters, stepped with the done pulse and pinned at all-ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd_cnt <= '0;
      o_wr_cnt <= '0;
    end else begin
      if (fin_rd && (o_rd_cnt != 32'hFFFF_FFFF)) o_rd_cnt <= o_rd_cnt + 32'd1;
      if (fin_wr && (o_wr_cnt != 32'hFFFF_FFFF)) o_wr_cnt <= o_wr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl (ADDR_W=18, WAIT_CYC=1, SKIP_EMPTY=1)
// with a behavioural asynchronous 16-bit SRAM on the pins.
module tb_sram_ctrl;

  localparam int ADDR_W = 18;

  logic CLOCK_50 = 1'b0;
  logic rst;

  always #10 CLOCK_50 = ~CLOCK_50;

  sram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  wire  [15:0]       sram_dq;
  logic [ADDR_W-1:0] sram_addr;
  logic              ce_n, oe_n, we_n, lb_n, ub_n;
`ifdef SRAM_CTRL_PERF_EN
  logic [31:0]       rd_cnt, wr_cnt;
`endif

  sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYC(1), .SKIP_EMPTY(1'b1)) dut (
    .i_clk       (CLOCK_50),
    .i_rst       (rst),
    .bus         (bus),
    .o_sram_addr (sram_addr),
    .io_sram_dq  (sram_dq),
    .o_sram_ce_n (ce_n),
    .o_sram_oe_n (oe_n),
    .o_sram_we_n (we_n),
    .o_sram_lb_n (lb_n),
    .o_sram_ub_n (ub_n)
`ifdef SRAM_CTRL_PERF_EN
    ,
    .o_rd_cnt    (rd_cnt),
    .o_wr_cnt    (wr_cnt)
`endif
  );

  // SRAM model: drives on read enable, writes enabled bytes while we_n is low
  logic [15:0] mem [0:255];
  logic        model_drive;
  assign model_drive = !ce_n && !oe_n && we_n;
  assign sram_dq = model_drive ? mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge CLOCK_50) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] t_addr [1:20];
  logic [4:0]        t_ctl  [1:20];
  logic [15:0]       t_dq   [1:20];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ctl_now();
    return {ce_n, oe_n, we_n, lb_n, ub_n};
  endfunction

  // bit 4 = ce_n, 3 = oe_n, 2 = we_n, 1 = lb_n, 0 = ub_n
  function automatic int low_cnt(input int bitn, input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) if (t_ctl[c][bitn] == 1'b0) n++;
    return n;
  endfunction

  task automatic start(input logic we, input logic [16:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    @(negedge CLOCK_50);
    bus.i_we    = we;
    bus.i_addr  = a;
    bus.i_be    = be;
    bus.i_wdata = wd;
    bus.i_req   = 1'b1;
    @(negedge CLOCK_50);
    bus.i_req   = 1'b0;
    bus.i_we    = ~we;
    bus.i_addr  = 17'h1FFFF;
    bus.i_be    = ~be;
    bus.i_wdata = ~wd;
  endtask

  task automatic xfer(input logic we, input logic [16:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output int lat);
    start(we, a, be, wd);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      t_addr[c] = sram_addr;
      t_ctl[c]  = ctl_now();
      t_dq[c]   = sram_dq;
      if (bus.o_wdone || bus.o_rvalid) begin
        lat = c;
        break;
      end
      @(negedge CLOCK_50);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int wd_seen;
    logic [3:0] wd_pat, rdy_pat;

    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_addr  = '0;
    bus.i_be    = '0;
    bus.i_wdata = '0;
    repeat (3) @(negedge CLOCK_50);

    chk("rst_ready",  32'(bus.o_ready),  32'h1);
    chk("rst_rvalid", 32'(bus.o_rvalid), 32'h0);
    chk("rst_wdone",  32'(bus.o_wdone),  32'h0);
    chk("rst_rdata",  bus.o_rdata,       32'h0);
    chk("rst_addr",   32'(sram_addr),    32'h0);
    chk("rst_ctl",    32'(ctl_now()),    32'h1F);
    chk("rst_dq_oe",  32'(dut.u_phy.dq_oe), 32'h0);
    rst = 1'b0;

    // Reset during beat-1 STROBE of a write
    start(1'b1, 17'h00030, 4'hF, 32'h12345678);
    repeat (4) @(negedge CLOCK_50);
    chk("mid_addr", 32'(sram_addr), 32'h61);
    chk("mid_we_n", 32'(we_n),      32'h0);
    rst = 1'b1;
    #1;
    chk("arst_ctl",   32'(ctl_now()),       32'h1F);
    chk("arst_dq_oe", 32'(dut.u_phy.dq_oe), 32'h0);
    chk("arst_addr",  32'(sram_addr),       32'h0);
    chk("arst_ready", 32'(bus.o_ready),     32'h1);
    @(negedge CLOCK_50);
    rst = 1'b0;
    wd_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLOCK_50);
      if (bus.o_wdone) wd_seen++;
    end
    chk("arst_no_wdone", 32'(wd_seen),  32'h0);
    chk("arst_ready2",   32'(bus.o_ready), 32'h1);

    // Full word write
    xfer(1'b1, 17'h00010, 4'hF, 32'hDEADBEEF, lat);
    chk("wr_lat",    32'(lat),        32'd7);
    chk("wr_addr1",  32'(t_addr[1]),  32'h20);
    chk("wr_addr3",  32'(t_addr[3]),  32'h20);
    chk("wr_addr4",  32'(t_addr[4]),  32'h21);
    chk("wr_addr6",  32'(t_addr[6]),  32'h21);
    chk("wr_dq_b0",  32'(t_dq[2]),    32'hBEEF);
    chk("wr_dq_b1",  32'(t_dq[5]),    32'hDEAD);
    chk("wr_we_b0",  32'(low_cnt(2, 1, 3)), 32'd2);
    chk("wr_we_b1",  32'(low_cnt(2, 4, 6)), 32'd2);
    chk("wr_ce_low", 32'(low_cnt(4, 1, 6)), 32'd6);
    chk("wr_ctl_done", 32'(t_ctl[7]), 32'h1F);
    chk("wr_mem_lo", 32'(mem[8'h20]), 32'hBEEF);
    chk("wr_mem_hi", 32'(mem[8'h21]), 32'hDEAD);
    @(negedge CLOCK_50);
    chk("wr_dq_rel", 32'(dut.u_phy.dq_oe), 32'h0);
    chk("wr_ready",  32'(bus.o_ready),     32'h1);

    // Read back
    xfer(1'b0, 17'h00010, 4'h0, 32'h0, lat);
    chk("rd_lat",    32'(lat),               32'd7);
    chk("rd_setup",  32'(t_ctl[1]),          32'h0C);
    chk("rd_oe_b0",  32'(low_cnt(3, 1, 3)),  32'd2);
    chk("rd_oe_b1",  32'(low_cnt(3, 4, 6)),  32'd2);
    chk("rd_no_we",  32'(low_cnt(2, 1, 6)),  32'd0);
    chk("rd_addr4",  32'(t_addr[4]),         32'h21);
    chk("rd_data",   bus.o_rdata,            32'hDEADBEEF);

    // Single-byte write in the upper half
    xfer(1'b1, 17'h00010, 4'b0100, 32'h00AA0000, lat);
    chk("bw_rdata_hold", bus.o_rdata,        32'hDEADBEEF);
    chk("bw_lat",    32'(lat),               32'd4);
    chk("bw_addr",   32'(t_addr[1]),         32'h21);
    chk("bw_setup",  32'(t_ctl[1]),          32'h0D);
    chk("bw_dq",     32'(t_dq[2]),           32'h00AA);
    chk("bw_we",     32'(low_cnt(2, 1, 3)),  32'd2);
    xfer(1'b0, 17'h00010, 4'hF, 32'h0, lat);
    chk("bw_rd_lat", 32'(lat),               32'd7);
    chk("bw_rd",     bus.o_rdata,            32'hDEAABEEF);

    // Empty write
    xfer(1'b1, 17'h00010, 4'h0, 32'h12345678, lat);
    chk("ew_lat",    32'(lat),               32'd1);
    chk("ew_no_ce",  32'(low_cnt(4, 1, 1)),  32'd0);
    chk("ew_rdata",  bus.o_rdata,            32'hDEAABEEF);

    // Back-to-back empty writes with i_req held high
    @(negedge CLOCK_50);
    bus.i_we    = 1'b1;
    bus.i_be    = 4'h0;
    bus.i_addr  = 17'h00010;
    bus.i_req   = 1'b1;
    wd_pat  = '0;
    rdy_pat = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLOCK_50);
      wd_pat  = {wd_pat[2:0], bus.o_wdone};
      rdy_pat = {rdy_pat[2:0], bus.o_ready};
      if (c == 3) bus.i_req = 1'b0;
    end
    chk("b2b_wdone", 32'(wd_pat),  32'hA);
    chk("b2b_ready", 32'(rdy_pat), 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
